block_interleaver: RTL and testbench

BLOCK_INTERLEAVER -- requirements
Module: block_interleaver

---
 rtl/block_interleaver.sv | 142 ++++++++++++++
 tb/tb_block_interleaver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/block_interleaver.sv
// Ping-pong block interleaver/deinterleaver: R codewords of L words are written row-wise
// into one bank while the other bank is read out column-wise (mode 1) or transposed back (mode 0).
module block_interleaver #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned ROW_LEN  = 65
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              s_mode,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              err_tlast
);

  localparam int unsigned BLK = NUM_ROWS * ROW_LEN;
  localparam int unsigned CW  = $clog2(BLK);
  localparam int unsigned MAW = $clog2(2 * BLK);

  logic [DATA_W-1:0] r_mem [2*BLK];

  logic [1:0]    r_full;
  logic [1:0]    r_bank_mode;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic          r_out_bank;
  logic          r_cur_mode;
  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [CW-1:0] r_a;
  logic [CW-1:0] r_a_base;
  logic [CW-1:0] r_b;

  logic           w_wr_fire;
  logic           w_wr_last;
  logic           w_blk_mode;
  logic           w_rd_load;
  logic           w_rd_last;
  logic           w_out_done;
  logic           w_rd_mode;
  logic           w_inner_wrap;
  logic           w_wr_bank_nxt;
  logic [1:0]     w_full_nxt;
  logic [CW-1:0]  w_step;
  logic [CW-1:0]  w_inner_max;
  logic [MAW-1:0] w_wr_addr;
  logic [MAW-1:0] w_rd_addr;

  // Read address = inner*step + outer, tracked incrementally (no multiplier).
  always_comb begin
    w_wr_fire     = s_axis_tvalid & s_axis_tready;
    w_wr_last     = (r_i == CW'(BLK - 1));
    w_blk_mode    = (r_i == '0) ? s_mode : r_cur_mode;
    w_rd_load     = r_full[r_rd_bank] & (~m_axis_tvalid | m_axis_tready);
    w_rd_last     = (r_j == CW'(BLK - 1));
    w_out_done    = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    w_rd_mode     = r_bank_mode[r_rd_bank];
    w_inner_max   = w_rd_mode ? CW'(NUM_ROWS - 1) : CW'(ROW_LEN - 1);
    w_step        = w_rd_mode ? CW'(ROW_LEN) : CW'(NUM_ROWS);
    w_inner_wrap  = (r_a == w_inner_max);
    w_wr_addr     = (r_wr_bank ? MAW'(BLK) : '0) + MAW'(r_i);
    w_rd_addr     = (r_rd_bank ? MAW'(BLK) : '0) + MAW'(r_a_base) + MAW'(r_b);
    w_full_nxt    = r_full;
    if (w_out_done) w_full_nxt[r_out_bank] = 1'b0;
    if (w_wr_fire && w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    w_wr_bank_nxt = r_wr_bank ^ (w_wr_fire & w_wr_last);
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire && !rst) r_mem[w_wr_addr] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full        <= '0;
      r_bank_mode   <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_out_bank    <= 1'b0;
      r_cur_mode    <= 1'b0;
      r_i           <= '0;
      r_j           <= '0;
      r_a           <= '0;
      r_a_base      <= '0;
      r_b           <= '0;
      s_axis_tready <= 1'b1;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      err_tlast     <= 1'b0;
    end else begin
      r_full        <= w_full_nxt;
      r_wr_bank     <= w_wr_bank_nxt;
      s_axis_tready <= ~w_full_nxt[w_wr_bank_nxt];

      if (w_wr_fire) begin
        r_cur_mode <= w_blk_mode;
        if (s_axis_tlast != w_wr_last) err_tlast <= 1'b1;
        if (w_wr_last) begin
          r_i                    <= '0;
          r_bank_mode[r_wr_bank] <= w_blk_mode;
        end else begin
          r_i <= r_i + CW'(1);
        end
      end

      // Output register reloads whenever it is empty or being consumed.
      if (w_rd_load) begin
        m_axis_tdata  <= r_mem[w_rd_addr];
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= w_rd_last;
        r_out_bank    <= r_rd_bank;
        if (w_rd_last) begin
          r_j       <= '0;
          r_a       <= '0;
          r_a_base  <= '0;
          r_b       <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_j <= r_j + CW'(1);
          if (w_inner_wrap) begin
            r_a      <= '0;
            r_a_base <= '0;
            r_b      <= r_b + CW'(1);
          end else begin
            r_a      <= r_a + CW'(1);
            r_a_base <= r_a_base + w_step;
          end
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_block_interleaver.sv
// Directed bench for block_interleaver (R=4, L=65): reorder order, back-pressure,
// framing error flag and mid-block reset.
module tb_block_interleaver;
  localparam int unsigned DW = 32;
  localparam int unsigned R  = 4;
  localparam int unsigned L  = 65;
  localparam int unsigned B  = R * L;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          s_mode;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          err_tlast;

  block_interleaver #(.DATA_W(DW), .NUM_ROWS(R), .ROW_LEN(L)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_mode(s_mode),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] in_d[$];
  logic        in_l[$];
  logic        in_m[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  int          in_cnt = 0;
  int          out_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          ready_val = 1'b0;
  bit          bubble_chk = 1'b0;
  bit          hold_valid = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue one block; s_mode is driven inverted after word 0 to prove it is ignored.
  task automatic push_block(input bit mode, input int tag, input int bad_idx);
    int idx;
    for (int i = 0; i < int'(B); i++) begin
      in_d.push_back(32'((tag << 16) | i));
      in_l.push_back((i == int'(B) - 1) || (i == bad_idx));
      in_m.push_back((i == 0) ? mode : ~mode);
    end
    for (int j = 0; j < int'(B); j++) begin
      if (mode) idx = (j % int'(R)) * int'(L) + j / int'(R);
      else      idx = (j % int'(L)) * int'(R) + j / int'(L);
      exp_d.push_back(32'((tag << 16) | idx));
      exp_l.push_back(j == int'(B) - 1);
    end
  endtask

  task automatic drive();
    s_axis_tvalid = (in_d.size() > 0);
    s_axis_tdata  = (in_d.size() > 0) ? in_d[0] : '0;
    s_axis_tlast  = (in_l.size() > 0) ? in_l[0] : 1'b0;
    s_mode        = (in_m.size() > 0) ? in_m[0] : 1'b0;
    m_axis_tready = rand_ready ? 1'($urandom_range(1, 0)) : ready_val;
  endtask

  task automatic tick();
    bit in_fire;
    bit out_fire;
    @(negedge clk);
    in_fire  = s_axis_tvalid && s_axis_tready;
    out_fire = m_axis_tvalid && m_axis_tready;
    if (hold_valid) begin
      chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
      chk("stall_data", m_axis_tdata, hold_data);
      chk("stall_last", 32'(m_axis_tlast), 32'(hold_last));
    end
    if (bubble_chk && out_cnt < 2 * int'(B)) chk("no_bubble", 32'(m_axis_tvalid), 32'd1);
    if (out_fire) begin
      chk("out_pending", 32'(exp_d.size() > 0), 32'd1);
      if (exp_d.size() > 0) begin
        chk("out_data", m_axis_tdata, exp_d[0]);
        chk("out_last", 32'(m_axis_tlast), 32'(exp_l[0]));
        void'(exp_d.pop_front());
        void'(exp_l.pop_front());
      end
      out_cnt++;
    end
    hold_valid = m_axis_tvalid && !m_axis_tready;
    hold_data  = m_axis_tdata;
    hold_last  = m_axis_tlast;
    if (in_fire) in_cnt++;
    @(posedge clk);
    #1;
    if (in_fire) begin
      void'(in_d.pop_front());
      void'(in_l.pop_front());
      void'(in_m.pop_front());
    end
    drive();
  endtask

  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles && (in_d.size() > 0 || exp_d.size() > 0); c++) tick();
    chk("drain_left", 32'(in_d.size() + exp_d.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_axis_tready), 32'd1);
    chk({tag, "_m_valid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_m_last"}, 32'(m_axis_tlast), 32'd0);
    chk({tag, "_m_data"}, m_axis_tdata, 32'd0);
    chk({tag, "_err"}, 32'(err_tlast), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("reset");

    // Mode 0 deinterleave, free-running output.
    ready_val = 1'b1;
    drive();
    push_block(1'b0, 0, -1);
    drain(1000);
    chk("m0_err", 32'(err_tlast), 32'd0);

    // Mode 1 interleave.
    push_block(1'b1, 1, -1);
    drain(1000);
    chk("m1_err", 32'(err_tlast), 32'd0);

    // Three blocks with output stalled until both banks fill.
    ready_val = 1'b0;
    drive();
    push_block(1'b0, 2, -1);
    push_block(1'b1, 3, -1);
    push_block(1'b0, 4, -1);
    in_cnt = 0;
    for (int c = 0; c < 800 && in_cnt < 2 * int'(B); c++) tick();
    chk("fill_count", 32'(in_cnt), 32'(2 * B));
    tick();
    tick();
    chk("full_s_ready", 32'(s_axis_tready), 32'd0);
    chk("full_m_valid", 32'(m_axis_tvalid), 32'd1);
    chk("full_first", m_axis_tdata, 32'h0002_0000);
    chk("full_in_cnt", 32'(in_cnt), 32'(2 * B));
    ready_val     = 1'b1;
    m_axis_tready = 1'b1;
    out_cnt       = 0;
    bubble_chk    = 1'b1;
    drain(3000);
    bubble_chk    = 1'b0;

    // Random output back-pressure.
    rand_ready = 1'b1;
    push_block(1'b0, 5, -1);
    drain(4000);
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    drive();

    // Early tlast on word 100 sets the sticky flag without disturbing framing.
    push_block(1'b0, 6, 100);
    in_cnt = 0;
    for (int c = 0; c < 400 && in_cnt < 100; c++) tick();
    chk("err_before", 32'(err_tlast), 32'd0);
    for (int c = 0; c < 10 && in_cnt < 101; c++) tick();
    chk("err_set", 32'(err_tlast), 32'd1);
    drain(1000);
    chk("err_sticky", 32'(err_tlast), 32'd1);

    // Reset mid-block, then a fresh block.
    push_block(1'b0, 7, -1);
    in_cnt = 0;
    for (int c = 0; c < 400 && in_cnt < 130; c++) tick();
    chk("pre_rst_cnt", 32'(in_cnt), 32'd130);
    in_d.delete();
    in_l.delete();
    in_m.delete();
    exp_d.delete();
    exp_l.delete();
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    hold_valid = 1'b0;
    check_reset_vals("midrst");
    push_block(1'b1, 8, -1);
    drive();
    drain(1000);
    chk("post_rst_err", 32'(err_tlast), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
